// File: rtl/fetch_stage_pipelined.sv
// fetch_stage_pipelined: PC register, imem addressing and IF/ID capture with
// stall/flush/redirect control and sticky misaligned-target fault.
module fetch_stage_pipelined #(
    parameter int              PC_W     = 64,
    parameter int              INSTR_W  = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              INCR     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic               br_taken_i,
    input  logic [PC_W-1:0]    br_target_i,
    output logic [PC_W-1:0]    imem_addr_o,
    input  logic [INSTR_W-1:0] imem_data_i,
    output logic [INSTR_W-1:0] ifid_instr_o,
    output logic [PC_W-1:0]    ifid_pc_o,
    output logic               ifid_valid_o,
    output logic               fault_o,
    output logic [PC_W-1:0]    fault_pc_o
);
    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0]    ifid_pc_q, ifid_pc_d;
    logic               valid_q, valid_d;
    logic               fault_q, fault_d;
    logic [PC_W-1:0]    fault_pc_q, fault_pc_d;
    logic               misaligned;
    logic [PC_W-1:0]    pc_next;

    assign misaligned = |(br_target_i & PC_W'(INCR - 1));
    assign pc_next    = pc_q + PC_W'(INCR);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        ifid_pc_d  = ifid_pc_q;
        valid_d    = 1'b0;
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (br_taken_i && misaligned) begin
                    state_d    = HALT;
                    fault_d    = 1'b1;
                    fault_pc_d = br_target_i;
                end else if (br_taken_i) begin
                    pc_d = br_target_i;
                end else if (stall_i) begin
                    valid_d = flush_i ? 1'b0 : valid_q;
                end else if (flush_i) begin
                    pc_d = pc_next;
                end else begin
                    pc_d      = pc_next;
                    instr_d   = imem_data_i;
                    ifid_pc_d = pc_q;
                    valid_d   = 1'b1;
                end
            end
            default: state_d = HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            ifid_pc_q  <= '0;
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            ifid_pc_q  <= ifid_pc_d;
            valid_q    <= valid_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
        end
    end

    assign imem_addr_o  = pc_q;
    assign ifid_instr_o = instr_q;
    assign ifid_pc_o    = ifid_pc_q;
    assign ifid_valid_o = valid_q;
    assign fault_o      = fault_q;
    assign fault_pc_o   = fault_pc_q;
endmodule

// File: tb/tb_fetch_stage_pipelined.sv
// tb_fetch_stage_pipelined: directed scenarios plus randomized run against a behavioural model.
module tb_fetch_stage_pipelined;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        br_taken = 1'b0;
    logic [63:0] br_target = '0;
    logic [63:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] ifid_instr;
    logic [63:0] ifid_pc;
    logic        ifid_valid;
    logic        fault;
    logic [63:0] fault_pc;
    logic [31:0] salt = '0;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    assign imem_data = imem_addr[31:0] ^ salt;

    fetch_stage_pipelined dut (
        .clk(clk), .reset(reset), .stall_i(stall), .flush_i(flush),
        .br_taken_i(br_taken), .br_target_i(br_target), .imem_addr_o(imem_addr),
        .imem_data_i(imem_data), .ifid_instr_o(ifid_instr), .ifid_pc_o(ifid_pc),
        .ifid_valid_o(ifid_valid), .fault_o(fault), .fault_pc_o(fault_pc)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic s, input logic f, input logic b, input logic [63:0] t);
        reset = r; stall = s; flush = f; br_taken = b; br_target = t;
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0, 0);
        tick(); tick();
        n_checks += 6;
        if (ifid_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", ifid_valid); end
        if (ifid_pc !== 64'h0) begin n_fail++; $display("FAIL reset_ifid_pc got %h want 0", ifid_pc); end
        if (ifid_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr got %h want 0", ifid_instr); end
        if (fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault got %b want 0", fault); end
        if (fault_pc !== 64'h0) begin n_fail++; $display("FAIL reset_fault_pc got %h want 0", fault_pc); end
        if (imem_addr !== 64'h0) begin n_fail++; $display("FAIL reset_imem_addr got %h want 0", imem_addr); end
    endtask

    task automatic test_free_run();
        drive(0, 0, 0, 0, 0);
        tick();
        n_checks += 2;
        if (ifid_valid !== 1'b0) begin n_fail++; $display("FAIL boot_valid got %b want 0", ifid_valid); end
        if (imem_addr !== 64'h0) begin n_fail++; $display("FAIL boot_pc got %h want 0", imem_addr); end
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks += 4;
            if (ifid_valid !== 1'b1) begin n_fail++; $display("FAIL run_valid[%0d] got %b want 1", k, ifid_valid); end
            if (ifid_pc !== 64'(4 * k)) begin n_fail++; $display("FAIL run_pc[%0d] got %h want %h", k, ifid_pc, 4 * k); end
            if (ifid_instr !== 32'(4 * k)) begin n_fail++; $display("FAIL run_instr[%0d] got %h want %h", k, ifid_instr, 4 * k); end
            if (imem_addr !== 64'(4 * k + 4)) begin n_fail++; $display("FAIL run_imem[%0d] got %h want %h", k, imem_addr, 4 * k + 4); end
        end
    endtask

    task automatic test_redirect();
        drive(0, 0, 0, 1, 64'h100);
        tick();
        n_checks += 2;
        if (ifid_valid !== 1'b0) begin n_fail++; $display("FAIL redir_bubble got %b want 0", ifid_valid); end
        if (imem_addr !== 64'h100) begin n_fail++; $display("FAIL redir_imem got %h want 100", imem_addr); end
        drive(0, 0, 0, 0, 0);
        tick();
        n_checks += 3;
        if (ifid_valid !== 1'b1) begin n_fail++; $display("FAIL redir_valid got %b want 1", ifid_valid); end
        if (ifid_pc !== 64'h100) begin n_fail++; $display("FAIL redir_pc got %h want 100", ifid_pc); end
        if (ifid_instr !== 32'h100) begin n_fail++; $display("FAIL redir_instr got %h want 100", ifid_instr); end
    endtask

    task automatic test_stall();
        drive(0, 0, 0, 1, 64'h1c);
        tick();
        drive(0, 0, 0, 0, 0);
        tick();
        drive(0, 1, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks += 3;
            if (imem_addr !== 64'h20) begin n_fail++; $display("FAIL stall_pc[%0d] got %h want 20", k, imem_addr); end
            if (ifid_pc !== 64'h1c || ifid_instr !== 32'h1c) begin n_fail++; $display("FAIL stall_ifid[%0d] got %h/%h want 1c/1c", k, ifid_pc, ifid_instr); end
            if (ifid_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d] got %b want 1", k, ifid_valid); end
        end
        drive(0, 0, 0, 0, 0);
        tick();
        n_checks += 2;
        if (ifid_pc !== 64'h20 || ifid_valid !== 1'b1) begin n_fail++; $display("FAIL stall_release got %h/%b want 20/1", ifid_pc, ifid_valid); end
        if (imem_addr !== 64'h24) begin n_fail++; $display("FAIL stall_release_pc got %h want 24", imem_addr); end
        drive(0, 1, 1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks += 2;
            if (ifid_valid !== 1'b0) begin n_fail++; $display("FAIL stallflush_valid[%0d] got %b want 0", k, ifid_valid); end
            if (imem_addr !== 64'h24) begin n_fail++; $display("FAIL stallflush_pc[%0d] got %h want 24", k, imem_addr); end
        end
        drive(0, 0, 0, 0, 0);
        tick();
        n_checks++;
        if (ifid_pc !== 64'h24 || ifid_valid !== 1'b1) begin n_fail++; $display("FAIL stallflush_release got %h/%b want 24/1", ifid_pc, ifid_valid); end
    endtask

    task automatic test_combined();
        drive(0, 1, 1, 1, 64'h40);
        tick();
        n_checks += 2;
        if (imem_addr !== 64'h40) begin n_fail++; $display("FAIL combo_pc got %h want 40", imem_addr); end
        if (ifid_valid !== 1'b0) begin n_fail++; $display("FAIL combo_valid got %b want 0", ifid_valid); end
        drive(0, 0, 0, 0, 0);
        tick();
        n_checks++;
        if (ifid_pc !== 64'h40 || ifid_valid !== 1'b1) begin n_fail++; $display("FAIL combo_after got %h/%b want 40/1", ifid_pc, ifid_valid); end
        drive(0, 0, 1, 0, 0);
        tick();
        n_checks += 2;
        if (ifid_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b want 0", ifid_valid); end
        if (imem_addr !== 64'h48) begin n_fail++; $display("FAIL flush_pc got %h want 48", imem_addr); end
        drive(0, 0, 0, 0, 0);
        tick();
        n_checks++;
        if (ifid_pc !== 64'h48 || ifid_valid !== 1'b1) begin n_fail++; $display("FAIL flush_after got %h/%b want 48/1", ifid_pc, ifid_valid); end
    endtask

    task automatic test_fault();
        drive(0, 0, 0, 1, 64'h102);
        for (int k = 0; k < 12; k++) begin
            tick();
            n_checks += 4;
            if (fault !== 1'b1) begin n_fail++; $display("FAIL halt_fault[%0d] got %b want 1", k, fault); end
            if (fault_pc !== 64'h102) begin n_fail++; $display("FAIL halt_fault_pc[%0d] got %h want 102", k, fault_pc); end
            if (ifid_valid !== 1'b0) begin n_fail++; $display("FAIL halt_valid[%0d] got %b want 0", k, ifid_valid); end
            if (imem_addr !== 64'h4c) begin n_fail++; $display("FAIL halt_pc[%0d] got %h want 4c", k, imem_addr); end
            drive(0, 1'($urandom), 1'($urandom), 1'($urandom), {56'h0, 8'($urandom)});
        end
        drive(1, 0, 0, 1, 64'h3);
        tick();
        n_checks += 3;
        if (fault !== 1'b0 || fault_pc !== 64'h0) begin n_fail++; $display("FAIL halt_reset_fault got %b/%h want 0/0", fault, fault_pc); end
        if (imem_addr !== 64'h0) begin n_fail++; $display("FAIL halt_reset_pc got %h want 0", imem_addr); end
        if (ifid_valid !== 1'b0) begin n_fail++; $display("FAIL halt_reset_valid got %b want 0", ifid_valid); end
        drive(0, 1, 1, 1, 64'h200);
        tick();
        n_checks++;
        if (imem_addr !== 64'h0 || ifid_valid !== 1'b0) begin n_fail++; $display("FAIL boot_ignore got %h/%b want 0/0", imem_addr, ifid_valid); end
        drive(0, 0, 0, 0, 0);
        tick();
        n_checks++;
        if (ifid_pc !== 64'h0 || ifid_valid !== 1'b1) begin n_fail++; $display("FAIL boot_first got %h/%b want 0/1", ifid_pc, ifid_valid); end
    endtask

    task automatic test_wrap();
        drive(0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        drive(0, 0, 0, 0, 0);
        tick();
        n_checks += 3;
        if (ifid_pc !== 64'hFFFF_FFFF_FFFF_FFFC || ifid_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_top got %h/%b want fffffffffffffffc/1", ifid_pc, ifid_valid); end
        if (ifid_instr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_instr got %h want fffffffc", ifid_instr); end
        if (imem_addr !== 64'h0) begin n_fail++; $display("FAIL wrap_imem got %h want 0", imem_addr); end
        tick();
        n_checks += 2;
        if (ifid_pc !== 64'h0 || ifid_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_zero got %h/%b want 0/1", ifid_pc, ifid_valid); end
        if (fault !== 1'b0) begin n_fail++; $display("FAIL wrap_fault got %b want 0", fault); end
    endtask

    task automatic test_reset_during_stall();
        tick();
        drive(0, 1, 0, 0, 0);
        tick();
        drive(1, 1, 0, 1, 64'h80);
        tick();
        n_checks += 3;
        if (ifid_valid !== 1'b0 || ifid_pc !== 64'h0 || ifid_instr !== 32'h0) begin n_fail++; $display("FAIL stall_reset_ifid got %b/%h/%h want 0/0/0", ifid_valid, ifid_pc, ifid_instr); end
        if (imem_addr !== 64'h0) begin n_fail++; $display("FAIL stall_reset_pc got %h want 0", imem_addr); end
        if (fault !== 1'b0 || fault_pc !== 64'h0) begin n_fail++; $display("FAIL stall_reset_fault got %b/%h want 0/0", fault, fault_pc); end
    endtask

    // Model: booting/running/halted with the fetch priority rules applied directly.
    task automatic test_random();
        int          phase = 0;
        logic [63:0] m_pc = 0, m_ipc = 0, m_fpc = 0;
        logic [31:0] m_instr = 0;
        bit          m_valid = 0, m_fault = 0;
        salt = $urandom;
        for (int k = 0; k < 600; k++) begin
            logic        r, s, f, b;
            logic [63:0] t;
            r = (k == 0) || ($urandom_range(0, 79) == 0);
            s = $urandom_range(0, 3) == 0;
            f = $urandom_range(0, 5) == 0;
            b = $urandom_range(0, 7) == 0;
            t = {$urandom, $urandom} & ~64'h3;
            if ($urandom_range(0, 5) == 0) t[1:0] = 2'($urandom_range(1, 3));
            drive(r, s, f, b, t);
            n_checks++;
            if (imem_addr !== m_pc) begin n_fail++; $display("FAIL rnd_imem[%0d] got %h want %h", k, imem_addr, m_pc); end
            if (r) begin
                phase = 0; m_pc = 0; m_ipc = 0; m_fpc = 0; m_instr = 0; m_valid = 0; m_fault = 0;
            end else if (phase != 1) begin
                if (phase == 0) phase = 1;
                m_valid = 0;
            end else if (b && (t % 4 != 0)) begin
                phase = 2; m_fault = 1; m_fpc = t; m_valid = 0;
            end else if (b) begin
                m_pc = t; m_valid = 0;
            end else if (s) begin
                if (f) m_valid = 0;
            end else if (f) begin
                m_pc = m_pc + 4; m_valid = 0;
            end else begin
                m_ipc = m_pc; m_instr = m_pc[31:0] ^ salt; m_pc = m_pc + 4; m_valid = 1;
            end
            tick();
            n_checks += 3;
            if (ifid_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid[%0d] got %b want %b", k, ifid_valid, m_valid); end
            if (fault !== m_fault || fault_pc !== m_fpc) begin n_fail++; $display("FAIL rnd_fault[%0d] got %b/%h want %b/%h", k, fault, fault_pc, m_fault, m_fpc); end
            if (m_valid && (ifid_pc !== m_ipc || ifid_instr !== m_instr)) begin n_fail++; $display("FAIL rnd_ifid[%0d] got %h/%h want %h/%h", k, ifid_pc, ifid_instr, m_ipc, m_instr); end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_free_run();
        test_redirect();
        test_stall();
        test_combined();
        test_fault();
        test_wrap();
        test_reset_during_stall();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
